// File: rtl/display_pkg.sv
// Shared encodings for the result sequencer and the display interface:
// system state codes, display status (DS) codes and default geometry.
package display_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10,
      ST_DISP = 2'b11
   } state_t;

   localparam logic [1:0] DS_INIT_ACK = 2'b01;
   localparam logic [1:0] DS_DONE     = 2'b10;

   localparam int ELEM_W_DEF = 8;
   localparam int N_ELEM_DEF = 4;

endpackage : display_pkg

// File: rtl/result_packer.sv
// Collects up to N_ELEM result bytes from one systolic array into a packed
// word, slot k at bits [k*ELEM_W +: ELEM_W]; accepts nothing once full.
module result_packer
   import display_pkg::*;
#(
   parameter int ELEM_W = ELEM_W_DEF,
   parameter int N_ELEM = N_ELEM_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_clear,
   input  logic                     i_en,
   input  logic                     i_valid,
   input  logic [ELEM_W-1:0]        i_data,
   output logic                     o_rdy,
   output logic                     o_full,
   output logic                     o_last,
   output logic [N_ELEM*ELEM_W-1:0] o_word
);

   localparam int CNT_W = $clog2(N_ELEM + 1);

   logic [CNT_W-1:0]        r_cnt;
   logic [N_ELEM*ELEM_W-1:0] r_word;
   logic                    w_take;

   assign o_full = (r_cnt == CNT_W'(N_ELEM));
   assign o_rdy  = i_en & ~o_full;
   assign w_take = i_valid & o_rdy;
   // Full now or filling on this edge: lets the FSM leave RUN on the same edge.
   assign o_last = o_full | (w_take & (r_cnt == CNT_W'(N_ELEM - 1)));
   assign o_word = r_word;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_word <= '0;
      end else if (i_clear) begin
         r_cnt  <= '0;
         r_word <= '0;
      end else if (w_take) begin
         // NOTE: non-blocking, so the slot index is the pre-increment count.
         r_word[r_cnt*ELEM_W +: ELEM_W] <= i_data;
         r_cnt                          <= r_cnt + 1'b1;
      end
   end

endmodule : result_packer

// File: rtl/result_sequencer.sv
// System sequencer and result packer feeding the display block.
// Optional DISPLAY watchdog enabled by defining RESULT_SEQ_TIMEOUT_EN.
module result_sequencer
   import display_pkg::*;
#(
   parameter int ELEM_W  = ELEM_W_DEF,
   parameter int N_ELEM  = N_ELEM_DEF,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [1:0]               DS,
   input  logic                     v22,
   input  logic [ELEM_W-1:0]        d22,
   input  logic                     v33,
   input  logic [ELEM_W-1:0]        d33,
   output logic                     rdy22,
   output logic                     rdy33,
   output logic [1:0]               state,
   output logic [N_ELEM*ELEM_W-1:0] ret22,
   output logic [N_ELEM*ELEM_W-1:0] ret33,
   output logic                     busy,
   output logic                     timeout_err
);

   state_t r_state;
   logic   w_run;
   logic   w_start;
   logic   w_last22;
   logic   w_last33;
   logic   w_full22;
   logic   w_full33;

   assign w_run   = (r_state == ST_RUN);
   assign w_start = (r_state == ST_INIT) & start & (DS == DS_INIT_ACK);
   assign state   = r_state;
   assign busy    = (r_state != ST_INIT);

   result_packer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_pack22 (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_start),
      .i_en    (w_run),
      .i_valid (v22),
      .i_data  (d22),
      .o_rdy   (rdy22),
      .o_full  (w_full22),
      .o_last  (w_last22),
      .o_word  (ret22)
   );

   result_packer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_pack33 (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_start),
      .i_en    (w_run),
      .i_valid (v33),
      .i_data  (d33),
      .o_rdy   (rdy33),
      .o_full  (w_full33),
      .o_last  (w_last33),
      .o_word  (ret33)
   );

`ifdef RESULT_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] r_wd;
   logic            r_timeout_err;

   assign timeout_err = r_timeout_err;
`else
   localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT);

   // No watchdog in this build; the AND keeps TIMEOUT referenced.
   assign timeout_err = 1'b0 & TIMEOUT_L[0];
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_INIT;
`ifdef RESULT_SEQ_TIMEOUT_EN
         r_wd          <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
`ifdef RESULT_SEQ_TIMEOUT_EN
         r_timeout_err <= 1'b0;
`endif
         case (r_state)
            ST_INIT: begin
               if (w_start) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_last22 & w_last33) r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               r_state <= ST_DISP;
`ifdef RESULT_SEQ_TIMEOUT_EN
               r_wd    <= '0;
`endif
            end
            ST_DISP: begin
               if (DS == DS_DONE) begin
                  r_state <= ST_INIT;
`ifdef RESULT_SEQ_TIMEOUT_EN
               end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                  r_state       <= ST_INIT;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_wd <= r_wd + 1'b1;
`endif
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   // Full flags are only consumed through o_last; kept visible for debug.
   logic w_unused;
   assign w_unused = w_full22 ^ w_full33;

endmodule : result_sequencer

// File: tb/tb_result_sequencer.sv
// Directed self-checking bench for result_sequencer (TIMEOUT=16); the
// watchdog section follows RESULT_SEQ_TIMEOUT_EN like the design.
module tb_result_sequencer;

   localparam logic [1:0] S_INIT = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_HOLD = 2'b10;
   localparam logic [1:0] S_DISP = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  DS;
   logic        v22, v33;
   logic [7:0]  d22, d33;
   logic        rdy22, rdy33;
   logic [1:0]  state;
   logic [31:0] ret22, ret33;
   logic        busy;
   logic        timeout_err;

   int n_checks = 0;
   int n_errors = 0;

   result_sequencer #(.ELEM_W(8), .N_ELEM(4), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .DS          (DS),
      .v22         (v22),
      .d22         (d22),
      .v33         (v33),
      .d33         (d33),
      .rdy22       (rdy22),
      .rdy33       (rdy33),
      .state       (state),
      .ret22       (ret22),
      .ret33       (ret33),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   // Advance one rising edge; outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0;
      v22 = 1'b0; v33 = 1'b0;
      d22 = 8'h00; d33 = 8'h00;
   endtask

   task automatic begin_run();
      DS = 2'b01; start = 1'b1;
      tick();
      start = 1'b0;
      check("run_entry_state", 32'(state), 32'(S_RUN));
      check("run_entry_rdy", {30'd0, rdy22, rdy33}, 32'h3);
   endtask

   // Back-to-back feed of both arrays, ending in DISPLAY.
   task automatic feed_both(input logic [31:0] w22, input logic [31:0] w33, input string tag);
      for (int k = 0; k < 4; k++) begin
         v22 = 1'b1; d22 = w22[8*k +: 8];
         v33 = 1'b1; d33 = w33[8*k +: 8];
         tick();
         check({tag, "_state"}, 32'(state), 32'((k == 3) ? S_HOLD : S_RUN));
      end
      idle_inputs();
      check({tag, "_hold_rdy"}, {30'd0, rdy22, rdy33}, 32'h0);
      tick();
      check({tag, "_disp_state"}, 32'(state), 32'(S_DISP));
      check({tag, "_ret22"}, ret22, w22);
      check({tag, "_ret33"}, ret33, w33);
   endtask

   initial begin
      rst = 1'b0; DS = 2'b00;
      idle_inputs();

      // Reset held with random activity on every input.
      for (int i = 0; i < 5; i++) begin
         start = 1'($urandom); DS = 2'($urandom);
         v22 = 1'($urandom); v33 = 1'($urandom);
         d22 = 8'($urandom); d33 = 8'($urandom);
         tick();
         check("rst_state", 32'(state), 32'(S_INIT));
         check("rst_outs", {ret22 | ret33, 28'd0}, 32'h0);
         check("rst_flags", {29'd0, rdy22, rdy33, busy}, 32'h0);
      end
      idle_inputs(); DS = 2'b00;
      rst = 1'b1;
      tick();
      check("rel_state", 32'(state), 32'(S_INIT));
      check("rel_ret", ret22 | ret33, 32'h0);
      check("rel_busy", {31'd0, busy}, 32'h0);

      // Start filtering in INIT: DS must be 01.
      start = 1'b1; DS = 2'b00;
      tick();
      check("start_ds00", 32'(state), 32'(S_INIT));
      DS = 2'b10;
      tick();
      check("start_ds10", 32'(state), 32'(S_INIT));
      start = 1'b0;

      // Normal run.
      begin_run();
      check("run_busy", {31'd0, busy}, 32'h1);
      feed_both(32'h04030201, 32'h302A241E, "norm");
      DS = 2'b01;
      tick();
      check("disp_ds01_stays", 32'(state), 32'(S_DISP));
      start = 1'b1;
      tick();
      start = 1'b0;
      check("disp_start_ignored", 32'(state), 32'(S_DISP));
      check("disp_start_ret22", ret22, 32'h04030201);
      DS = 2'b10;
      tick();
      check("done_state", 32'(state), 32'(S_INIT));
      check("done_busy", {31'd0, busy}, 32'h0);
      check("init_ret_kept", ret33, 32'h302A241E);
      DS = 2'b00;

      // Skew: 3x3 every cycle, 2x2 every other cycle; 3x3 pushes FF once full.
      begin_run();
      check("skew_entry_clear", ret22 | ret33, 32'h0);
      for (int i = 0; i < 7; i++) begin
         v22 = (i % 2 == 0); d22 = 8'h10 + 8'(i / 2);
         v33 = 1'b1;         d33 = (i < 4) ? 8'hA0 + 8'(i) : 8'hFF;
         tick();
         if (i >= 3) begin
            check("skew_rdy33", {31'd0, rdy33}, 32'h0);
            check("skew_ret33", ret33, 32'hA3A2A1A0);
         end
         check("skew_state", 32'(state), 32'((i == 6) ? S_HOLD : S_RUN));
      end
      v22 = 1'b1; d22 = 8'hEE;
      tick();
      idle_inputs();
      check("skew_disp", 32'(state), 32'(S_DISP));
      check("skew_ret22", ret22, 32'h13121110);
      DS = 2'b10;
      tick();
      DS = 2'b00;
      check("skew_exit", 32'(state), 32'(S_INIT));

      // Reset mid-RUN after two elements per array.
      begin_run();
      for (int k = 0; k < 2; k++) begin
         v22 = 1'b1; d22 = 8'hC0 + 8'(k);
         v33 = 1'b1; d33 = 8'hD0 + 8'(k);
         tick();
      end
      idle_inputs();
      check("mid_partial22", ret22, 32'h0000C1C0);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_state", 32'(state), 32'(S_INIT));
      check("mid_rst_ret", ret22 | ret33, 32'h0);
      check("mid_rst_flags", {29'd0, rdy22, rdy33, busy}, 32'h0);
      tick();
      rst = 1'b1;
      tick();
      begin_run();
      feed_both(32'h88776655, 32'h44332211, "fresh");
      DS = 2'b10;
      tick();
      check("fresh_exit", 32'(state), 32'(S_INIT));

      // Watchdog.
      begin_run();
      feed_both(32'h0A0B0C0D, 32'h01020304, "wd");
      DS = 2'b00;
`ifdef RESULT_SEQ_TIMEOUT_EN
      for (int c = 1; c <= 15; c++) begin
         tick();
         check("wd_wait_state", 32'(state), 32'(S_DISP));
         check("wd_wait_err", {31'd0, timeout_err}, 32'h0);
      end
      tick();
      check("wd_fire_err", {31'd0, timeout_err}, 32'h1);
      check("wd_fire_state", 32'(state), 32'(S_INIT));
      tick();
      check("wd_pulse_len", {31'd0, timeout_err}, 32'h0);

      begin_run();
      feed_both(32'h0A0B0C0D, 32'h01020304, "wd2");
      DS = 2'b00;
      for (int c = 1; c <= 15; c++) tick();
      check("wd2_last_wait", 32'(state), 32'(S_DISP));
      DS = 2'b10;
      tick();
      check("wd2_exit_state", 32'(state), 32'(S_INIT));
      check("wd2_no_err", {31'd0, timeout_err}, 32'h0);
`else
      for (int c = 1; c <= 40; c++) begin
         tick();
         check("nowd_state", 32'(state), 32'(S_DISP));
         check("nowd_err", {31'd0, timeout_err}, 32'h0);
      end
      DS = 2'b10;
      tick();
      check("nowd_exit", 32'(state), 32'(S_INIT));
`endif
      DS = 2'b00;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_result_sequencer

// File: doc/result_sequencer.md
# result_sequencer

Top-level sequencer and result packer feeding the display block. It drives the 2-bit system `state`, and collects the first 2x2 result bytes of the 2x2 and 3x3 systolic arrays into the packed `ret22`/`ret33` words. It handshakes with the display block through its 2-bit `DS` status. It sits between the systolic array outputs and the display module and is the producer end of the `state`/`ret`/`DS` interface.

## Interface
- `ELEM_W`, 8: width of one result element.
- `N_ELEM`, 4: elements per array, row-major 2x2; packed word width is `N_ELEM*ELEM_W`, 32 by default.
- `TIMEOUT`, 1024: DISPLAY watchdog limit in cycles; used only with the macro below.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request a new collection run.
- `DS` in 2: display status; `01` = init acknowledged, `10` = display done.
- `v22` / `d22` in 1 / `ELEM_W`: 2x2 array element valid and data.
- `v33` / `d33` in 1 / `ELEM_W`: 3x3 array element valid and data.
- `rdy22`, `rdy33` out 1: element accept ready, one per array.
- `state` out 2: `00` INIT, `01` RUN, `10` HOLD, `11` DISPLAY.
- `ret22`, `ret33` out 32: packed results; element k occupies bits `[8k+7:8k]`, with k = 2*row + col.
- `busy` out 1: high in every state except INIT.
- `timeout_err` out 1: one-cycle error pulse; tied to 0 without the macro.

## Operation
- Reset (`rst` low): `state`=00, `ret22`=`ret33`=0, counters=0, `rdy22`=`rdy33`=0, `busy`=0, `timeout_err`=0.
- INIT: `state`=00.
  - Go to RUN when `start`=1 and `DS`=01 in the same cycle.
  - Entering RUN clears both `ret` words and both counters.
  - `start` is ignored in every other state and ignored when `DS`≠01.
- RUN: `rdyXX` = (counter XX < `N_ELEM`).
  - An element transfers when `vXX`&`rdyXX` at a rising edge. The byte is written at slot counter XX, then the counter increments.
  - The two arrays are independent and may transfer in the same cycle.
  - `vXX` while `rdyXX`=0 is ignored: no overflow and no wrap.
  - When both counters equal `N_ELEM`, go to HOLD.
- HOLD: `rdy`=0. Unconditionally go to DISPLAY on the next edge, so `ret` words are stable for one full cycle before `state`=11.
- DISPLAY: `state`=11; `ret` words are held constant.
  - Go to INIT when `DS`=10.
  - `DS`=01 or 00 keeps the block in DISPLAY.
  - `ret` words stay valid in INIT until the next RUN entry.
- Reset asserted in any state forces the reset values immediately; partial results are discarded.

## Timing
- Element accepted at edge N appears in `ret` after edge N.
- Last outstanding element accepted at edge N: `state`=10 after N, `state`=11 after N+1.
- `DS`=10 sampled at edge M in DISPLAY: `state`=00 after M.
- `start`&`DS`=01 at edge S: `state`=01 and `rdy`=1 after S.
- Minimum run: 4 accept cycles + HOLD + DISPLAY + 1.
- All outputs are registered except `rdyXX` and `busy`, which decode from registered state and counters only.

## Configuration
- `RESULT_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs in DISPLAY and clears on entry.
  - If `DS`≠10 for `TIMEOUT` consecutive DISPLAY cycles, `timeout_err` pulses high for one cycle and `state` returns to 00 on that same edge.
  - `DS`=10 on the final cycle wins: normal exit, no error.
- Not defined: no counter is built, `timeout_err` is constant 0, and DISPLAY waits indefinitely.

## Structure
- Package `display_pkg` holds:
  - `state_t` encodings `ST_INIT`, `ST_RUN`, `ST_HOLD`, `ST_DISP`.
  - DS codes `DS_INIT_ACK`=01 and `DS_DONE`=10.
  - Default `ELEM_W` and `N_ELEM` constants.
- Sub-module `result_packer`, instanced once per array, contains:
  - the slot counter and `rdy` generation;
  - the byte-lane write and the `full` flag;
  - a `clear` input driven on RUN entry.
- The FSM, watchdog and output muxing stay in `result_sequencer`.

## Test plan
- Reset: hold `rst`=0 with random inputs → `state`=00, `ret22`=`ret33`=0, `rdy`=0, `busy`=0; release → values unchanged.
- Normal run: `DS`=01 and `start` pulse, feed `d22`=01,02,03,04 and `d33`=1E,24,2A,30 back-to-back.
  - `ret22`=0x04030201 and `ret33`=0x302A241E.
  - `state` goes 01→10→11; then `DS`=10 → 00 next edge.
- Skew and backpressure: finish 3x3 first, then drive `v33`=1 with data FF for 3 more cycles → `rdy33`=0 and `ret33` unchanged.
  - The 2x2 array delivers one element every other cycle; HOLD starts only after its 4th element.
- Reset mid-RUN after 2 elements per array → everything clears; a fresh run packs correctly from slot 0.
- Start filtering: `start` with `DS`=00 stays in INIT; `start` in DISPLAY is ignored and `ret` words are unchanged.
- Watchdog (macro on, `TIMEOUT`=16): in DISPLAY hold `DS`=00 → after 16 cycles `timeout_err` is high for exactly one cycle and `state`=00.
  - Repeat with `DS`=10 on cycle 16 → normal exit, no error.
